// File: rtl/sec_counter.sv
// Seconds counter: a prescaler divides clk down to a one-second tick, and a
// 4-bit digit counter steps 0..MAX_COUNT once per tick and then wraps to 0.
module sec_counter #(
    parameter int TICK_CYCLES = 100_000_000,
    parameter int MAX_COUNT   = 9
) (
    input  logic       clk,
    input  logic       res,
    output logic [3:0] s_num
);

    // A single-cycle tick still needs one bit of storage.
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_CYCLES - 1);
    localparam logic [3:0]    DIGIT_MAX = 4'(MAX_COUNT);

    logic [PW-1:0] r_pre;
    logic [3:0]    r_s_num;
    logic          w_tick;

    assign w_tick = (r_pre == PRE_LAST);

    // Wrap explicitly so that non-power-of-two periods do not run on to overflow.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_s_num <= 4'd0;
        end else if (w_tick) begin
            if (r_s_num == DIGIT_MAX) begin
                r_s_num <= 4'd0;
            end else begin
                r_s_num <= r_s_num + 4'd1;
            end
        end
    end

    assign s_num = r_s_num;

endmodule

// File: tb/tb_sec_counter.sv
// Bench for sec_counter: three parameterisations share clk and res, and each
// is checked against an "edges since release" arithmetic model.
module tb_sec_counter;

    localparam int TA = 10, MA = 9;
    localparam int TB = 1,  MB = 3;
    localparam int TC = 7,  MC = 15;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic [3:0] s_a, s_b, s_c;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    int edges_n = 0;

    sec_counter #(.TICK_CYCLES(TA), .MAX_COUNT(MA)) dut_a (.clk(clk), .res(res), .s_num(s_a));
    sec_counter #(.TICK_CYCLES(TB), .MAX_COUNT(MB)) dut_b (.clk(clk), .res(res), .s_num(s_b));
    sec_counter #(.TICK_CYCLES(TC), .MAX_COUNT(MC)) dut_c (.clk(clk), .res(res), .s_num(s_c));

    always #5 clk = ~clk;

    // Reference: rising edges seen with res high since the last reset.
    always @(posedge clk or negedge res) begin
        if (!res) edges_n <= 0;
        else      edges_n <= edges_n + 1;
    end

    function automatic logic [3:0] model(input int n, input int t, input int m);
        return 4'((n / t) % (m + 1));
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_a", s_a, model(edges_n, TA, MA));
            check("model_b", s_b, model(edges_n, TB, MB));
            check("model_c", s_c, model(edges_n, TC, MC));
        end
    end

    typedef struct {
        int         edges;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        logic [3:0] exp_c;
    } vec_t;

    vec_t vecs [9];
    int   done;
    bit   found;

    initial begin
        vecs[0] = '{9,   4'd0, 4'd1, 4'd1};
        vecs[1] = '{10,  4'd1, 4'd2, 4'd1};
        vecs[2] = '{19,  4'd1, 4'd3, 4'd2};
        vecs[3] = '{20,  4'd2, 4'd0, 4'd2};
        vecs[4] = '{55,  4'd5, 4'd3, 4'd7};
        vecs[5] = '{99,  4'd9, 4'd3, 4'd14};
        vecs[6] = '{100, 4'd0, 4'd0, 4'd14};
        vecs[7] = '{111, 4'd1, 4'd3, 4'd15};
        vecs[8] = '{112, 4'd1, 4'd0, 4'd0};

        res = 1'b0;
        #12;
        check("por_a", s_a, 4'd0);
        check("por_b", s_b, 4'd0);
        check("por_c", s_c, 4'd0);
        #5 res = 1'b1;
        $display("[TB] release at t=%0t", $time);
        chk_en = 1'b1;

        done = 0;
        for (int i = 0; i < 9; i++) begin
            repeat (vecs[i].edges - done) @(posedge clk);
            #1;
            check("tbl_a", s_a, vecs[i].exp_a);
            check("tbl_b", s_b, vecs[i].exp_b);
            check("tbl_c", s_c, vecs[i].exp_c);
            done = vecs[i].edges;
            $display("[TB] vec %0d edge %0d: a=%0d b=%0d c=%0d", i, done, s_a, s_b, s_c);
        end

        // Long reset hold: nothing may move while res is low.
        @(negedge clk);
        #2 res = 1'b0;
        #1;
        check("hold_async_a", s_a, 4'd0);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            check("hold_a", s_a, 4'd0);
            check("hold_b", s_b, 4'd0);
            check("hold_c", s_c, 4'd0);
        end
        $display("[TB] 50-cycle reset hold done");
        @(negedge clk);
        #2 res = 1'b1;

        // Async reset while digit A shows 5, then first increment 10 edges later.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (s_a == 4'd5) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL wait_for_5: got timeout, expected s_num==5 within 200 cycles");
        end
        #2 res = 1'b0;
        #1;
        check("mid_async_a", s_a, 4'd0);
        check("mid_async_c", s_c, 4'd0);
        @(negedge clk);
        #2 res = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            check("restart_a", s_a, (i == 10) ? 4'd1 : 4'd0);
        end
        $display("[TB] mid-run reset and restart done");

        // Randomised run lengths and reset placements, judged by the model.
        for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(1, 60)) @(negedge clk);
            #($urandom_range(1, 3)) res = 1'b0;
            #1;
            check("rnd_rst_a", s_a, 4'd0);
            check("rnd_rst_b", s_b, 4'd0);
            check("rnd_rst_c", s_c, 4'd0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            #2 res = 1'b1;
            $display("[TB] random burst %0d released at t=%0t", k, $time);
        end
        repeat (120) @(negedge clk);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
